pipeline_hazard_ctrl: RTL and testbench

Central hazard and pipeline-sequencing controller for the 5-stage RISC-V core. It sits beside the pipeline register chain (IF/ID, ID/EX, EX/MEM, MEM/WB) and drives those registers' `stall`, `nop` and active-low `WEN` inputs. It detects load-use hazards, squashes wrong-path instructions on a taken branch, freezes the pipeline while data memory is busy, and drains and freezes the core on `halt`. It also keeps cycle, stall and flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 87 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use/branch/mem-wait/halt control for the 5-stage pipe (hazard inputs in, stall/nop/WEN controls and perf counters out)
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic             Rs1Used_D,
  input  logic             Rs2Used_D,
  input  logic [4:0]       Rdst_E,
  input  logic             RegWrEn_E,
  input  logic             IsLoad_E,
  input  logic             BrTaken_E,
  input  logic             halt_D,
  input  logic             halt_W,
  input  logic             MemBusy_M,
  output logic             PC_WEN,
  output logic             IFID_stall,
  output logic             IFID_nop,
  output logic             IDEX_stall,
  output logic             IDEX_nop,
  output logic             EXMEM_WEN,
  output logic             MEMWB_WEN,
  output logic             Halted,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);
  typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} state_t;
  state_t state, state_nxt;
  logic drain_pend, drain_pend_nxt;
  logic lu, freeze, br_sq, lu_st, drn, stall_ev;
  assign lu = IsLoad_E && !RegWrEn_E && (Rdst_E != 5'd0) &&
              ((Rs1Used_D && Rs1_D == Rdst_E) || (Rs2Used_D && Rs2_D == Rdst_E));
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= RUN;
      drain_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      drain_pend <= drain_pend_nxt;
    end
  end
  always_comb begin
    state_nxt      = state;
    drain_pend_nxt = drain_pend;
    case (state)
      RUN:     state_nxt = MemBusy_M ? MEMWAIT : (halt_D && !BrTaken_E) ? DRAIN : RUN;
      MEMWAIT: begin
        state_nxt      = MemBusy_M ? MEMWAIT : drain_pend ? DRAIN : RUN;
        drain_pend_nxt = MemBusy_M && drain_pend;
      end
      DRAIN:   begin
        state_nxt      = MemBusy_M ? MEMWAIT : halt_W ? HALTED : DRAIN;
        drain_pend_nxt = MemBusy_M;
      end
      HALTED:  state_nxt = HALTED;
    endcase
  end
  always_comb begin
    Halted     = !RST && state == HALTED;
    freeze     = !RST && (state == HALTED || MemBusy_M);
    br_sq      = !RST && !freeze && BrTaken_E;
    lu_st      = !RST && !freeze && !BrTaken_E && lu;
    drn        = !RST && !freeze && !BrTaken_E && !lu && (state == DRAIN || (state == RUN && halt_D));
    stall_ev   = lu_st || (!RST && MemBusy_M && state != HALTED);
    PC_WEN     = freeze || lu_st || drn;
    IFID_stall = freeze || lu_st;
    IFID_nop   = br_sq || drn;
    IDEX_stall = freeze;
    IDEX_nop   = br_sq || lu_st;
    EXMEM_WEN  = freeze;
    MEMWB_WEN  = freeze;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      CycleCnt <= '0;
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      CycleCnt <= CycleCnt + CNT_W'(state != HALTED);
      StallCnt <= StallCnt + CNT_W'(stall_ev);
      FlushCnt <= FlushCnt + CNT_W'(br_sq);
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for pipeline_hazard_ctrl against a rule-level reference model
module tb_pipeline_hazard_ctrl;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1, rs2, rd;
  logic u1, u2, wen, ld, br, hd, hw, mb;
  logic pc_wen, ifid_stall, ifid_nop, idex_stall, idex_nop, exmem_wen, memwb_wen, halted;
  logic [W-1:0] cyc_cnt, stall_cnt, flush_cnt;
  typedef struct packed {
    logic rst;
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, wen, ld, br, hd, hw, mb;
  } in_t;
  typedef struct packed {
    logic [7:0] ctrl;
    logic [W-1:0] cyc, stl, fl;
    bit cnt_chk;
  } exp_t;
  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  bit m_known = 0, m_halted = 0, m_drain = 0, m_wait = 0, m_pend = 0;
  logic [W-1:0] m_cyc, m_stl, m_fl;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.CNT_W(W)) dut (
    .CLK(clk), .RST(rst), .Rs1_D(rs1), .Rs2_D(rs2), .Rs1Used_D(u1), .Rs2Used_D(u2),
    .Rdst_E(rd), .RegWrEn_E(wen), .IsLoad_E(ld), .BrTaken_E(br), .halt_D(hd),
    .halt_W(hw), .MemBusy_M(mb), .PC_WEN(pc_wen), .IFID_stall(ifid_stall),
    .IFID_nop(ifid_nop), .IDEX_stall(idex_stall), .IDEX_nop(idex_nop),
    .EXMEM_WEN(exmem_wen), .MEMWB_WEN(memwb_wen), .Halted(halted),
    .CycleCnt(cyc_cnt), .StallCnt(stall_cnt), .FlushCnt(flush_cnt)
  );
  function automatic in_t idle();
    in_t s;
    s = '0;
    s.wen = 1'b1;
    return s;
  endfunction
  task automatic push_exp(input in_t s);
    exp_t e;
    bit lu, pcw, ifs, ifn, ids, idn, frz, hl;
    lu = s.ld && !s.wen && s.rd != 0 &&
         ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    {pcw, ifs, ifn, ids, idn, frz, hl} = '0;
    e.cnt_chk = m_known;
    e.cyc = m_cyc;
    e.stl = m_stl;
    e.fl = m_fl;
    if (s.rst) begin
      {m_halted, m_drain, m_wait, m_pend} = '0;
      m_cyc = 0; m_stl = 0; m_fl = 0;
      m_known = 1;
    end else begin
      if (m_halted) begin
        frz = 1; hl = 1;
      end else if (s.mb) begin
        frz = 1; m_stl++;
      end else if (s.br) begin
        ifn = 1; idn = 1; m_fl++;
      end else if (lu) begin
        pcw = 1; ifs = 1; idn = 1; m_stl++;
      end else if (m_drain || (!m_wait && s.hd)) begin
        pcw = 1; ifn = 1;
      end
      if (frz) begin
        pcw = 1; ifs = 1; ids = 1;
      end
      if (!m_halted) m_cyc++;
      if (m_halted) begin
      end else if (m_wait) begin
        if (!s.mb) begin
          m_wait = 0; m_drain = m_pend; m_pend = 0;
        end
      end else if (m_drain) begin
        if (s.mb) begin
          m_wait = 1; m_pend = 1; m_drain = 0;
        end else if (s.hw) begin
          m_halted = 1; m_drain = 0;
        end
      end else if (s.mb) m_wait = 1;
      else if (s.hd && !s.br) m_drain = 1;
    end
    e.ctrl = {pcw, ifs, ifn, ids, idn, frz, frz, hl};
    exp_q.push_back(e);
  endtask
  task automatic step(input in_t s);
    @(posedge clk);
    #1;
    rst = s.rst; rs1 = s.rs1; rs2 = s.rs2; rd = s.rd; u1 = s.u1; u2 = s.u2;
    wen = s.wen; ld = s.ld; br = s.br; hd = s.hd; hw = s.hw; mb = s.mb;
    push_exp(s);
  endtask
  task automatic do_reset();
    in_t s;
    s = idle();
    s.rst = 1;
    step(s);
  endtask
  task automatic idles(input int n);
    for (int i = 0; i < n; i++) step(idle());
  endtask
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {pc_wen, ifid_stall, ifid_nop, idex_stall, idex_nop, exmem_wen, memwb_wen, halted};
      n_tests++;
      if (act !== e.ctrl) begin
        n_fail++;
        $display("FAIL ctrl at %0t: got %b want %b", $time, act, e.ctrl);
      end
      if (e.cnt_chk) begin
        n_tests += 3;
        if (cyc_cnt !== e.cyc) begin
          n_fail++;
          $display("FAIL CycleCnt at %0t: got %0d want %0d", $time, cyc_cnt, e.cyc);
        end
        if (stall_cnt !== e.stl) begin
          n_fail++;
          $display("FAIL StallCnt at %0t: got %0d want %0d", $time, stall_cnt, e.stl);
        end
        if (flush_cnt !== e.fl) begin
          n_fail++;
          $display("FAIL FlushCnt at %0t: got %0d want %0d", $time, flush_cnt, e.fl);
        end
      end
    end
  end
  initial begin
    in_t s;
    {rst, rs1, rs2, rd, u1, u2, wen, ld, br, hd, hw, mb} = '0;
    do_reset();
    idles(2);
    s = idle(); s.ld = 1; s.wen = 0; s.rd = 5; s.u2 = 1; s.rs2 = 5;
    step(s);
    idles(1);
    s.rd = 0; s.rs2 = 0;
    step(s);
    s = idle(); s.ld = 1; s.wen = 0; s.rd = 7; s.u1 = 1; s.rs1 = 7; s.br = 1;
    step(s);
    idles(2);
    s = idle(); s.br = 1; s.hd = 1;
    step(s);
    idles(3);
    do_reset();
    idles(9);
    s = idle(); s.hd = 1; step(s);
    idles(2);
    s = idle(); s.hw = 1; step(s);
    idles(4);
    s = idle(); s.mb = 1; step(s);
    do_reset();
    idles(3);
    s = idle(); s.hd = 1; step(s);
    idles(1);
    s = idle(); s.mb = 1;
    repeat (3) step(s);
    idles(2);
    s = idle(); s.hw = 1; step(s);
    idles(3);
    for (int seg = 0; seg < 30; seg++) begin
      do_reset();
      for (int i = 0; i < 40; i++) begin
        s.rst = 0;
        s.rs1 = 5'($urandom_range(0, 3));
        s.rs2 = 5'($urandom_range(0, 3));
        s.rd = 5'($urandom_range(0, 3));
        s.u1 = 1'($urandom_range(0, 1));
        s.u2 = 1'($urandom_range(0, 1));
        s.wen = $urandom_range(0, 9) < 3;
        s.ld = 1'($urandom_range(0, 1));
        s.br = $urandom_range(0, 99) < 15;
        s.hd = $urandom_range(0, 99) < 10;
        s.hw = $urandom_range(0, 99) < 15;
        s.mb = $urandom_range(0, 99) < 15;
        s.rst = $urandom_range(0, 99) < 2;
        step(s);
      end
    end
    do_reset();
    for (int i = 0; i < 300; i++) begin
      s = idle();
      s.rs1 = 5'($urandom_range(0, 3));
      s.rd = 5'($urandom_range(0, 3));
      s.u1 = 1;
      s.ld = 1'($urandom_range(0, 1));
      s.wen = 0;
      s.br = $urandom_range(0, 99) < 20;
      s.mb = $urandom_range(0, 99) < 20;
      step(s);
    end
    idles(1);
    @(posedge clk);
    @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
